spi_opcode_master: RTL and testbench

- SPI initiator (mode 0, MSB first) for the opcode/reply protocol the game logic serves as responder.
- Each frame is 32 SCK cycles:
  - bits 31..24: master sends the 8-bit opcode on MOSI.
  - bits 23..0: master samples the 24-bit reply on MISO.
- Decodes level replies (opcode 0x1z) and key-match replies (opcode 0x2z) into registered fields.
- Used as a loopback/self-test master and to drive a secondary status display in place of the Pi.

---
 rtl/spi_opcode_master.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_opcode_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_opcode_master.sv
// SPI mode-0 opcode/reply initiator: 8-bit opcode out, 24-bit reply in.
// Define AUTO_POLL_EN to self-issue alternating 0x10/0x20 frames.
module spi_opcode_master #(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n,
  output logic [23:0] reply,
  output logic        death,
  output logic [2:0]  total_life,
  output logic [1:0]  level,
  output logic [15:0] key_seq,
  output logic        correct_key,
  output logic        wrong_key,
  output logic        level_valid,
  output logic        match_valid
);

`ifdef AUTO_POLL_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t state_q, state_d;

  logic [15:0] div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [23:0] rx_q, rx_d;
  logic [7:0]  op_q, op_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        done_q, done_d;
  logic        poll_q, poll_d;
  logic [23:0] reply_q, reply_d;
  logic        death_q, death_d;
  logic [2:0]  life_q, life_d;
  logic [1:0]  level_q, level_d;
  logic [15:0] key_q, key_d;
  logic        ck_q, ck_d;
  logic        wk_q, wk_d;
  logic        lv_q, lv_d;
  logic        mv_q, mv_d;

  logic [15:0] lim;
  logic        tc;
  logic        go;
  logic        launch;
  logic [7:0]  op_sel;

  assign lim = (state_q == GAP) ? 16'(GAP_CYCLES - 1)
                                : 16'(CLK_DIV - 1);
  assign tc  = (div_q == lim);
  assign go  = AUTO ? 1'b1 : start;
  assign op_sel = AUTO ? (poll_q ? 8'h20 : 8'h10) : opcode;
  assign launch = ((state_q == IDLE) && go) ||
                  (AUTO && (state_q == GAP) && tc);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: phase advances on the divider terminal count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (go) state_d = SETUP;
      SETUP: if (tc) state_d = SHIFT;
      SHIFT: if (tc && sck_q && bit_q == 6'd32) state_d = HOLD;
      HOLD:  if (tc) state_d = GAP;
      GAP:   if (tc) state_d = AUTO ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next values: divider, shifters, reply decode.
  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    op_d    = op_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    poll_d  = poll_q;
    reply_d = reply_q;
    death_d = death_q;
    life_d  = life_q;
    level_d = level_q;
    key_d   = key_q;
    ck_d    = ck_q;
    wk_d    = wk_q;
    lv_d    = lv_q;
    mv_d    = mv_q;
    if (state_q != IDLE) div_d = tc ? 16'd0 : div_q + 16'd1;
    if (state_q == SHIFT && tc) begin
      sck_d = ~sck_q;
      if (!sck_q) begin
        rx_d  = {rx_q[22:0], miso};
        bit_d = bit_q + 6'd1;
      end else begin
        tx_d   = tx_q << 1;
        mosi_d = tx_q[30];
      end
    end
    if (state_q == HOLD && tc) begin
      cs_n_d  = 1'b1;
      done_d  = 1'b1;
      reply_d = rx_q;
      casez (op_q)
        8'b0001????: begin
          death_d = rx_q[23];
          life_d  = rx_q[22:20];
          level_d = rx_q[17:16];
          key_d   = rx_q[15:0];
          lv_d    = 1'b1;
        end
        8'b0010????: begin
          ck_d = rx_q[23];
          wk_d = rx_q[22];
          mv_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (launch) begin
      op_d   = op_sel;
      tx_d   = {op_sel, 24'h0};
      mosi_d = op_sel[7];
      cs_n_d = 1'b0;
      sck_d  = 1'b0;
      div_d  = 16'd0;
      bit_d  = 6'd0;
      poll_d = ~poll_q;
    end
  end

  // Datapath registers; reset forces the bus idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      op_q    <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      poll_q  <= 1'b0;
      reply_q <= '0;
      death_q <= 1'b0;
      life_q  <= '0;
      level_q <= '0;
      key_q   <= '0;
      ck_q    <= 1'b0;
      wk_q    <= 1'b0;
      lv_q    <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      op_q    <= op_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      poll_q  <= poll_d;
      reply_q <= reply_d;
      death_q <= death_d;
      life_q  <= life_d;
      level_q <= level_d;
      key_q   <= key_d;
      ck_q    <= ck_d;
      wk_q    <= wk_d;
      lv_q    <= lv_d;
      mv_q    <= mv_d;
    end
  end

  assign done        = done_q;
  assign sck         = sck_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign reply       = reply_q;
  assign death       = death_q;
  assign total_life  = life_q;
  assign level       = level_q;
  assign key_seq     = key_q;
  assign correct_key = ck_q;
  assign wrong_key   = wk_q;
  assign level_valid = lv_q;
  assign match_valid = mv_q;

endmodule

// File: tb/tb_spi_opcode_master.sv
// Bench for spi_opcode_master: responder model, frame-level
// reference model and per-cycle compare, plus literal checks.
module tb_spi_opcode_master;
  localparam int CD  = 4;
  localparam int GAP = 16;
  localparam int LAT = 66 * CD + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        miso = 1'b0;
  logic        busy, done, sck, mosi, cs_n;
  logic [23:0] reply;
  logic        death;
  logic [2:0]  total_life;
  logic [1:0]  level;
  logic [15:0] key_seq;
  logic        correct_key, wrong_key;
  logic        level_valid, match_valid;

  spi_opcode_master #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .busy(busy), .done(done), .sck(sck), .mosi(mosi),
    .miso(miso), .cs_n(cs_n), .reply(reply), .death(death),
    .total_life(total_life), .level(level), .key_seq(key_seq),
    .correct_key(correct_key), .wrong_key(wrong_key),
    .level_valid(level_valid), .match_valid(match_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Responder: presents bit 31 on cs_n fall, advances on sck fall.
  logic [31:0] resp_frame = 32'h0;
  int ridx = 0;
  always @(negedge cs_n) begin
    ridx = 31;
    miso = resp_frame[31];
  end
  always @(negedge sck) begin
    if (!cs_n && ridx > 0) begin
      ridx--;
      miso = resp_frame[ridx];
    end
  end

  // What the responder sees on MOSI at each sck rise.
  logic [31:0] mosi_cap = 32'h0;
  int rises = 0;
  always @(negedge cs_n) begin
    mosi_cap = 32'h0;
    rises = 0;
  end
  always @(posedge sck) begin
    if (!cs_n) begin
      mosi_cap = {mosi_cap[30:0], mosi};
      rises++;
    end
  end

  // Frame-level model: a frame accepted at cycle s is fully timed
  // by s, LAT and GAP; fields change only when its done is due.
  bit          m_on = 1'b0;
  int          m_s = -1000000;
  logic [7:0]  m_op = 8'h0;
  logic [23:0] m_rep = 24'h0;
  logic [23:0] m_reply = 24'h0;
  logic [22:0] m_lvl = 23'h0;
  logic [1:0]  m_key = 2'b0;
  logic        m_lv = 1'b0;
  logic        m_mv = 1'b0;
  int          done_cnt = 0;

  task automatic model_reset();
    m_s = -1000000;
    m_reply = 24'h0;
    m_lvl = 23'h0;
    m_key = 2'b0;
    m_lv = 1'b0;
    m_mv = 1'b0;
  endtask

  always @(negedge clk) begin
    if (m_on && !reset) begin
      if (done) done_cnt++;
      if (cyc == m_s + LAT) begin
        m_reply = m_rep;
        if (m_op[7:4] == 4'h1) begin
          m_lvl = {m_rep[23:20], m_rep[17:16], m_rep[15:0]};
          m_lv = 1'b1;
        end
        if (m_op[7:4] == 4'h2) begin
          m_key = m_rep[23:22];
          m_mv = 1'b1;
        end
      end
      chk("done", {31'h0, done}, {31'h0, cyc == m_s + LAT});
      chk("cs_n", {31'h0, cs_n},
          {31'h0, !(cyc > m_s && cyc < m_s + LAT)});
      chk("busy", {31'h0, busy},
          {31'h0, (cyc > m_s && cyc < m_s + LAT + GAP)});
      chk("reply", {8'h0, reply}, {8'h0, m_reply});
      chk("level_fields",
          {9'h0, death, total_life, level, key_seq},
          {9'h0, m_lvl});
      chk("key_fields",
          {28'h0, correct_key, wrong_key, level_valid, match_valid},
          {28'h0, m_key, m_lv, m_mv});
    end
  end

  int got_lat;

  // One frame; optional extra start pulse at loop step extra_at.
  task automatic do_frame(input logic [7:0] op,
                          input logic [23:0] rep,
                          input int extra_at);
    int s;
    int got;
    @(posedge clk); #2;
    resp_frame = {8'hA5, rep};
    opcode = op;
    start = 1'b1;
    s = cyc;
    if (cyc >= m_s + LAT + GAP) begin
      m_s = cyc;
      m_op = op;
      m_rep = rep;
    end
    @(posedge clk); #2;
    start = 1'b0;
    opcode = 8'h00;
    got = -1;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      start = (i == extra_at);
      if (i == extra_at) opcode = 8'h21;
      if (done && got < 0) got = cyc;
    end
    start = 1'b0;
    if (got < 0) chk("done_timeout", 32'h0, 32'h1);
    got_lat = got - s;
    repeat (GAP + 4) @(negedge clk);
  endtask

`ifdef AUTO_POLL_EN
  logic [7:0] exp_ops [4];
  initial begin
    int hi;
    bit ok;
    exp_ops = '{8'h10, 8'h20, 8'h10, 8'h20};
    resp_frame = 32'h0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge clk);
        ok = !cs_n;
      end
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge clk);
        ok = cs_n;
      end
      if (!ok) chk("frame_timeout", 32'h0, 32'h1);
      chk("auto_opcode", {24'h0, mosi_cap[31:24]},
          {24'h0, exp_ops[f]});
      chk("auto_busy", {31'h0, busy}, 32'h1);
      if (f < 3) begin
        hi = 1;
        for (int i = 0; i < 400 && cs_n; i++) begin
          @(negedge clk);
          if (cs_n) hi++;
        end
        chk("auto_gap", hi, GAP);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
`else
  initial begin
    int d0;
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'h0, cs_n}, 32'h1);
    chk("rst_sck", {31'h0, sck}, 32'h0);
    chk("rst_mosi", {31'h0, mosi}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_reply", {8'h0, reply}, 32'h0);
    chk("rst_valid", {30'h0, level_valid, match_valid}, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    m_on = 1'b1;

    do_frame(8'h15, 24'hF3ABCD, -1);
    chk("s1_latency", got_lat, 265);
    chk("s1_mosi", mosi_cap, 32'h1500_0000);
    chk("s1_death", {31'h0, death}, 32'h1);
    chk("s1_life", {29'h0, total_life}, 32'h7);
    chk("s1_level", {30'h0, level}, 32'h3);
    chk("s1_key", {16'h0, key_seq}, 32'hABCD);
    chk("s1_lv", {31'h0, level_valid}, 32'h1);
    chk("s1_mv", {31'h0, match_valid}, 32'h0);

    do_frame(8'h20, 24'h800000, -1);
    chk("s2_mosi", mosi_cap, 32'h2000_0000);
    chk("s2_keys", {30'h0, correct_key, wrong_key}, 32'h2);
    chk("s2_mv", {31'h0, match_valid}, 32'h1);
    chk("s2_key_hold", {16'h0, key_seq}, 32'hABCD);
    chk("s2_death_hold", {31'h0, death}, 32'h1);

    do_frame(8'h00, 24'h123456, -1);
    chk("s3_reply", {8'h0, reply}, 32'h123456);
    chk("s3_key_hold", {16'h0, key_seq}, 32'hABCD);
    chk("s3_keys_hold", {30'h0, correct_key, wrong_key}, 32'h2);
    chk("s3_valid", {30'h0, level_valid, match_valid}, 32'h3);

    d0 = done_cnt;
    do_frame(8'h24, 24'h400000, 8);
    repeat (LAT) @(negedge clk);
    chk("s4_one_done", done_cnt - d0, 1);
    chk("s4_keys", {30'h0, correct_key, wrong_key}, 32'h1);

    d0 = done_cnt;
    @(posedge clk); #2;
    resp_frame = {8'hA5, 24'h654321};
    opcode = 8'h11;
    start = 1'b1;
    m_s = cyc;
    m_op = 8'h11;
    m_rep = 24'h654321;
    @(posedge clk); #2;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (rises >= 12);
    end
    if (!hit) chk("s5_edge_timeout", 32'h0, 32'h1);
    @(negedge clk);
    chk("s5_sck_high", {31'h0, sck}, 32'h1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("s5_cs_n_async", {31'h0, cs_n}, 32'h1);
    chk("s5_sck_async", {31'h0, sck}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (LAT + GAP + 20) @(negedge clk);
    chk("s5_no_done", done_cnt - d0, 0);
    chk("s5_reply", {8'h0, reply}, 32'h0);
    chk("s5_lv", {31'h0, level_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
`endif

endmodule
